ram_write_queue: RTL and testbench
==================================

Name: ram_write_queue

Overview:
- Write-side front end for the 9-entry, 15-bit CPU register RAM.
- Accepts write requests over a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle onto the RAM write port (WA/WRD/WE) and flags pending writes that collide with the RAM read addresses.
- Also sequences a clear-all operation that zeroes every RAM entry.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
NREGS, 9, number of valid RAM addresses (0..NREGS-1)

Ports:
CLK  input  1  clock, rising edge
RSTN  input  1  asynchronous active-low reset
req_valid  input  1  write request present
req_ready  output  1  queue can accept request this cycle
req_addr  input  4  target RAM address
req_data  input  15  write data
stall  input  1  1 = hold RAM write port (no WE, no pop/advance)
init  input  1  request clear-all (single-cycle pulse, sampled in RUN only)
hz_addr1  input  4  RAM read address 1 to check
hz_addr2  input  4  RAM read address 2 to check
WA  output  4  RAM write address
WRD  output  15  RAM write data
WE  output  1  RAM write enable
hazard  output  1  pending write to hz_addr1/hz_addr2, or busy
busy  output  1  clear-all in progress
err  output  1  one-cycle pulse: out-of-range request discarded

Behaviour:
- Clock and reset: one clock CLK; reset RSTN is asynchronous, active-low.
- Reset state:
  - FIFO empty, state RUN, clear counter 0.
  - err=0, WE=0, WA=0, WRD=0, hazard=0, busy=0, req_ready=1.
  - Reset mid-operation flushes the FIFO and aborts any clear.
- FSM states:
  - RUN -> INIT_WAIT on init=1.
  - INIT_WAIT -> INIT_CLR when FIFO empty.
  - INIT_CLR -> RUN after address NREGS-1 is written.
  - init is ignored outside RUN.
- req_ready is combinational: (state==RUN) & (count<DEPTH).
- Handshake:
  - A request transfers on a rising edge with req_valid & req_ready.
  - If req_addr <= NREGS-1, {addr,data} is pushed.
  - Otherwise the request is accepted but discarded, and err=1 for exactly the following cycle.
- A request on the same edge that init is sampled is accepted normally; it is drained before the clear, so the clear overwrites it.
- Drain in RUN/INIT_WAIT (combinational from FIFO head):
  - WE = !empty & !stall.
  - WA = head addr, WRD = head data.
  - When empty: WA=0, WRD=0.
  - Pop on each edge where WE=1.
- Latency: a request accepted at edge k into an empty FIFO with stall=0 gives WE=1 during the cycle after edge k; the RAM writes it at edge k+1.
- Push and pop on the same edge: count unchanged, order preserved (strict FIFO).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH; full blocks push; empty blocks pop.
- INIT_CLR:
  - WE = !stall, WA = counter, WRD = 0.
  - Counter increments on each edge with WE=1.
  - After the write of NREGS-1: counter returns to 0, state returns to RUN.
- busy = 1 in INIT_WAIT and INIT_CLR.
- hazard (combinational):
  - busy = 1, or
  - any valid FIFO entry's addr equals hz_addr1 or hz_addr2.
  - The in-flight incoming request is not included.
  - An entry popping this cycle still counts.

Test Plan:
1. Reset: assert RSTN=0 mid-cycle -> immediately WE=0, WA=0, WRD=0, err=0, busy=0, hazard=0, req_ready=1.
2. Single write: stall=0, push addr 3 / data 15'h1ABC at edge 1 -> next cycle WE=1, WA=3, WRD=15'h1ABC; WE=0 the cycle after.
3. Fill/drain: stall=1, push addrs 0,1,2,3 -> req_ready=0 after 4th push, WE=0. Release stall -> WE=1 for 4 consecutive cycles with WA=0,1,2,3, then req_ready=1.
4. Out of range: push addr 9, data 15'h0055 -> err=1 for one cycle, no WE, FIFO count unchanged; addr 15 behaves the same.
5. Hazard: stall=1, push addr 5.
   - hz_addr1=5 -> hazard=1.
   - hz_addr1=6, hz_addr2=5 -> hazard=1.
   - Both 6 -> hazard=0.
   - Release stall -> hazard=0 the cycle after the pop.
6. Clear-all: stall=1, two entries queued (addrs 2,4); pulse init; release stall.
   - Required: busy=1 and req_ready=0 from the cycle after init.
   - WA=2, then 4, then WA=0..8 with WRD=0 over 9 cycles.
   - busy=0 and req_ready=1 afterwards.
   - Asserting stall during the clear holds WA; asserting RSTN=0 during the clear returns to RUN with busy=0.

Source files
------------

// File: rtl/ram_write_queue.sv
// Write-side front end for the CPU register RAM: a small request FIFO that
// drains one entry per cycle onto the RAM write port, plus a clear-all
// sequencer that zeroes every RAM address after the FIFO has emptied.
module ram_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREGS = 9
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_addr,
  input  logic [14:0] req_data,
  input  logic        stall,
  input  logic        init,
  input  logic [3:0]  hz_addr1,
  input  logic [3:0]  hz_addr2,
  output logic [3:0]  WA,
  output logic [14:0] WRD,
  output logic        WE,
  output logic        hazard,
  output logic        busy,
  output logic        err
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam logic [3:0]  MAX_ADDR = 4'(NREGS - 1);

  typedef enum logic [1:0] {
    RUN,
    INIT_WAIT,
    INIT_CLR
  } state_t;

  state_t        state;
  logic [3:0]    clr_cnt;
  logic [3:0]    fifo_addr [DEPTH];
  logic [14:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic empty;
  logic accept;
  logic in_range;
  logic push;
  logic pop;

  assign empty     = (count == '0);
  assign req_ready = (state == RUN) && (count < (PW+1)'(DEPTH));
  assign accept    = req_valid & req_ready;
  assign in_range  = (req_addr <= MAX_ADDR);
  assign push      = accept & in_range;
  assign pop       = WE & (state != INIT_CLR);
  assign busy      = (state != RUN);

  // RAM write port: clear counter during clear-all, otherwise the FIFO head
  always_comb begin
    WE  = 1'b0;
    WA  = '0;
    WRD = '0;
    if (state == INIT_CLR) begin
      WE = !stall;
      WA = clr_cnt;
    end else if (!empty) begin
      WE  = !stall;
      WA  = fifo_addr[rd_ptr];
      WRD = fifo_data[rd_ptr];
    end
  end

  // Hazard: clear in progress, or any queued entry (including the one popping) hits a read address
  always_comb begin
    hazard = busy;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((PW+1)'(i) < count) begin
        if (fifo_addr[rd_ptr + PW'(i)] == hz_addr1 ||
            fifo_addr[rd_ptr + PW'(i)] == hz_addr2) begin
          hazard = 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents beyond count are never observed, so no reset
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= req_addr;
      fifo_data[wr_ptr] <= req_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control FSM: clear-all sequencing and the out-of-range error pulse
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= RUN;
      clr_cnt <= '0;
      err     <= 1'b0;
    end else begin
      err <= accept & !in_range;
      case (state)
        RUN: begin
          if (init) state <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (empty) state <= INIT_CLR;
        end
        INIT_CLR: begin
          if (WE) begin
            if (clr_cnt == MAX_ADDR) begin
              clr_cnt <= '0;
              state   <= RUN;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_write_queue.sv
// Self-checking bench for ram_write_queue: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a queue-based model.
module tb_ram_write_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NREGS = 9;

  logic        CLK;
  logic        RSTN;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic [14:0] req_data;
  logic        stall;
  logic        init;
  logic [3:0]  hz_addr1;
  logic [3:0]  hz_addr2;
  logic [3:0]  WA;
  logic [14:0] WRD;
  logic        WE;
  logic        hazard;
  logic        busy;
  logic        err;

  ram_write_queue #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .stall(stall), .init(init),
    .hz_addr1(hz_addr1), .hz_addr2(hz_addr2),
    .WA(WA), .WRD(WRD), .WE(WE),
    .hazard(hazard), .busy(busy), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model
  typedef enum int {M_RUN, M_WAIT, M_CLR} mode_t;
  typedef struct packed {
    logic [3:0]  a;
    logic [14:0] d;
  } ent_t;

  ent_t  q[$];
  mode_t mode;
  int    clr;
  bit    err_m;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode  = M_RUN;
    clr   = 0;
    err_m = 0;
  endtask

  // One clock cycle: drive at negedge, check outputs, advance the model at posedge.
  task automatic step(input bit v, input logic [3:0] a, input logic [14:0] d,
                      input bit s, input bit i, input logic [3:0] h1, input logic [3:0] h2);
    bit          e_ready, e_busy, e_we, e_haz, acc;
    logic [3:0]  e_wa;
    logic [14:0] e_wrd;
    int          pre_size;
    req_valid = v; req_addr = a; req_data = d;
    stall = s; init = i; hz_addr1 = h1; hz_addr2 = h2;
    #1;
    e_ready = (mode == M_RUN) && (q.size() < DEPTH);
    e_busy  = (mode != M_RUN);
    if (mode == M_CLR) begin
      e_we = !s; e_wa = 4'(clr); e_wrd = '0;
    end else if (q.size() > 0) begin
      e_we = !s; e_wa = q[0].a; e_wrd = q[0].d;
    end else begin
      e_we = 0; e_wa = '0; e_wrd = '0;
    end
    e_haz = e_busy;
    foreach (q[k]) if (q[k].a == h1 || q[k].a == h2) e_haz = 1;
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("busy",      32'(busy),      32'(e_busy));
    check("WE",        32'(WE),        32'(e_we));
    check("WA",        32'(WA),        32'(e_wa));
    check("WRD",       32'(WRD),       32'(e_wrd));
    check("hazard",    32'(hazard),    32'(e_haz));
    check("err",       32'(err),       32'(err_m));
    @(posedge CLK);
    pre_size = q.size();
    acc   = v && e_ready;
    err_m = acc && (a >= NREGS);
    if (mode != M_CLR && e_we) void'(q.pop_front());
    if (acc && a < NREGS) q.push_back('{a: a, d: d});
    case (mode)
      M_RUN:  if (i) mode = M_WAIT;
      M_WAIT: if (pre_size == 0) mode = M_CLR;
      M_CLR:  if (e_we) begin
                if (clr == NREGS - 1) begin clr = 0; mode = M_RUN; end
                else clr++;
              end
      default: mode = M_RUN;
    endcase
    @(negedge CLK);
  endtask

  // Asynchronous reset pulse mid-cycle, with immediate checks of the reset values.
  task automatic do_reset();
    #2;
    RSTN = 1'b0;
    #1;
    check("rst_WE",     32'(WE),        32'd0);
    check("rst_WA",     32'(WA),        32'd0);
    check("rst_WRD",    32'(WRD),       32'd0);
    check("rst_err",    32'(err),       32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_hazard", 32'(hazard),    32'd0);
    check("rst_ready",  32'(req_ready), 32'd1);
    model_reset();
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic idle(input bit s, input int n);
    for (int k = 0; k < n; k++) step(0, 4'd0, 15'd0, s, 0, 4'd15, 4'd15);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RSTN = 1'b1; req_valid = 0; req_addr = '0; req_data = '0;
    stall = 0; init = 0; hz_addr1 = 4'd15; hz_addr2 = 4'd15;
    model_reset();
    @(negedge CLK);
    do_reset();

    // Single write
    step(1, 4'd3, 15'h1ABC, 0, 0, 4'd15, 4'd15);
    idle(0, 2);

    // Fill under stall, then drain
    for (int k = 0; k < 4; k++) step(1, 4'(k), 15'(16'h100 + k), 1, 0, 4'd15, 4'd15);
    step(1, 4'd7, 15'h7777, 1, 0, 4'd15, 4'd15);
    idle(0, 6);

    // Out-of-range requests
    step(1, 4'd9, 15'h0055, 0, 0, 4'd15, 4'd15);
    step(1, 4'd15, 15'h0066, 0, 0, 4'd15, 4'd15);
    idle(0, 2);

    // Hazard detection
    step(1, 4'd5, 15'h0A5A, 1, 0, 4'd15, 4'd15);
    step(0, 4'd0, 15'd0, 1, 0, 4'd5, 4'd15);
    step(0, 4'd0, 15'd0, 1, 0, 4'd6, 4'd5);
    step(0, 4'd0, 15'd0, 1, 0, 4'd6, 4'd6);
    step(0, 4'd0, 15'd0, 0, 0, 4'd5, 4'd5);
    step(0, 4'd0, 15'd0, 0, 0, 4'd5, 4'd5);

    // Clear-all with queued entries, stall mid-clear
    step(1, 4'd2, 15'h0222, 1, 0, 4'd15, 4'd15);
    step(1, 4'd4, 15'h0444, 1, 0, 4'd15, 4'd15);
    step(0, 4'd0, 15'd0, 1, 1, 4'd15, 4'd15);
    idle(0, 6);
    idle(1, 2);
    idle(0, 10);

    // Reset during a clear
    step(0, 4'd0, 15'd0, 0, 1, 4'd15, 4'd15);
    idle(0, 4);
    do_reset();
    idle(0, 2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 60,
             ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)),
             15'($urandom),
             $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 3,
             4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
